uart: RTL and testbench

Full-duplex serial transceiver carrying one BIT_LEN-bit word per frame over a single-wire channel, one bit per clock. Two instances are cross-connected through channel models (plain wire or noise injector) to form a point-to-point link. The receiver flags each completed frame as valid or corrupted, using parity and stop-bit checks.

---
 rtl/uart.sv | 241 ++++++++++++++++++++++++
 tb/tb_uart.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart.sv
// Full-duplex UART transceiver. Each frame is a start bit, BIT_LEN data bits
// sent LSB first, an optional even-parity bit and a stop bit, one bit per clock.
// Build option: define UART_PARITY_EN to send and check the parity bit.
// rx reports each completed frame; the line idles high, and the tx accepts a
// new word only while it is idle.

module uart_tx #(
  parameter int BIT_LEN = 7
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start_i,
  input  logic [BIT_LEN-1:0] data_i,
  output logic               line_o
);
  localparam int CW = (BIT_LEN > 1) ? $clog2(BIT_LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(BIT_LEN - 1);

  typedef enum logic [2:0] {IDLE = 3'd0, START, DATA, PARITY, STOP} state_t;

  state_t             state, state_d;
  logic [BIT_LEN-1:0] data_q, data_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               line_q, line_d;
`ifdef UART_PARITY_EN
  logic               par_q, par_d;
`endif

  // State, shift register and registered line output.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state  <= IDLE;
      data_q <= '0;
      cnt_q  <= '0;
      line_q <= 1'b1;
`ifdef UART_PARITY_EN
      par_q  <= 1'b0;
`endif
    end else begin
      state  <= state_d;
      data_q <= data_d;
      cnt_q  <= cnt_d;
      line_q <= line_d;
`ifdef UART_PARITY_EN
      par_q  <= par_d;
`endif
    end
  end

  // Next state; line_d is the bit to drive during the state being entered.
  always_comb begin
    state_d = state;
    data_d  = data_q;
    cnt_d   = cnt_q;
    line_d  = line_q;
`ifdef UART_PARITY_EN
    par_d   = par_q;
`endif
    case (state)
      IDLE: begin
        line_d = 1'b1;
        if (start_i) begin
          state_d = START;
          data_d  = data_i;
          cnt_d   = '0;
          line_d  = 1'b0;
`ifdef UART_PARITY_EN
          par_d   = ^data_i;
`endif
        end
      end
      START: begin
        state_d = DATA;
        line_d  = data_q[0];
        data_d  = data_q >> 1;
      end
      DATA: begin
        if (cnt_q == LAST) begin
`ifdef UART_PARITY_EN
          state_d = PARITY;
          line_d  = par_q;
`else
          state_d = STOP;
          line_d  = 1'b1;
`endif
        end else begin
          cnt_d  = cnt_q + 1'b1;
          line_d = data_q[0];
          data_d = data_q >> 1;
        end
      end
`ifdef UART_PARITY_EN
      PARITY: begin
        state_d = STOP;
        line_d  = 1'b1;
      end
`endif
      STOP: begin
        state_d = IDLE;
        line_d  = 1'b1;
      end
      default: begin
        state_d = IDLE;
        line_d  = 1'b1;
      end
    endcase
  end

  assign line_o = line_q;
endmodule

module uart_rx #(
  parameter int BIT_LEN = 7
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               line_i,
  output logic [BIT_LEN-1:0] data_o,
  output logic               vld_o
);
  localparam int CW = (BIT_LEN > 1) ? $clog2(BIT_LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(BIT_LEN - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, DATA, PARITY, STOP} state_t;

  state_t             state, state_d;
  logic [BIT_LEN-1:0] shift_q, shift_d;
  logic [BIT_LEN-1:0] data_q, data_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               vld_q, vld_d;
`ifdef UART_PARITY_EN
  logic               par_q, par_d;
`endif

  // State, shift register and the held result of the last frame.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state   <= IDLE;
      shift_q <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
`ifdef UART_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state   <= state_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
`ifdef UART_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Next state: sample one line bit per clock; publish the word on the stop sample.
  always_comb begin
    state_d = state;
    shift_d = shift_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    vld_d   = vld_q;
`ifdef UART_PARITY_EN
    par_d   = par_q;
`endif
    case (state)
      IDLE: begin
        if (!line_i) begin
          state_d = DATA;
          cnt_d   = '0;
          vld_d   = 1'b0;
        end
      end
      DATA: begin
        // Bits arrive LSB first, so shift right and insert at the MSB.
        shift_d = shift_q >> 1;
        shift_d[BIT_LEN-1] = line_i;
        if (cnt_q == LAST) begin
`ifdef UART_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef UART_PARITY_EN
      PARITY: begin
        par_d   = line_i;
        state_d = STOP;
      end
`endif
      STOP: begin
        // The word is published even when the frame is corrupted.
        data_d  = shift_q;
`ifdef UART_PARITY_EN
        vld_d   = line_i & (par_q == ^shift_q);
`else
        vld_d   = line_i;
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign data_o = data_q;
  assign vld_o  = vld_q;
endmodule

module uart #(
  parameter int BIT_LEN = 7
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               tx_start,
  input  logic [BIT_LEN-1:0] tx_data_in,
  output logic               tx_channel_out,
  input  logic               rx_channel_in,
  output logic [BIT_LEN-1:0] rx_data_out,
  output logic               rx_out_vaild
);
  uart_tx #(.BIT_LEN(BIT_LEN)) tx (
    .clk     (clk),
    .rstn    (rstn),
    .start_i (tx_start),
    .data_i  (tx_data_in),
    .line_o  (tx_channel_out)
  );

  uart_rx #(.BIT_LEN(BIT_LEN)) rx (
    .clk     (clk),
    .rstn    (rstn),
    .line_i  (rx_channel_in),
    .data_o  (rx_data_out),
    .vld_o   (rx_out_vaild)
  );
endmodule

// File: tb/tb_uart.sv
// Two cross-connected uart instances; the A->B channel can invert single bits.
// Expected frames go into per-receiver queues and are checked on frame completion.
module tb_uart;
`ifdef UART_PARITY_EN
  localparam int LAT = 10;
  localparam bit PAR = 1'b1;
  localparam logic [15:0] PAT_59 = 16'b11010110010;
  localparam logic [15:0] PAT_2A = 16'b11101010100;
`else
  localparam int LAT = 9;
  localparam bit PAR = 1'b0;
  localparam logic [15:0] PAT_59 = 16'b1110110010;
  localparam logic [15:0] PAT_2A = 16'b1101010100;
`endif

  typedef struct packed {
    logic [6:0]  d;
    logic        v;
    logic [31:0] c;
  } exp_t;

  typedef struct packed {
    logic        b;
    logic [31:0] c;
  } lexp_t;

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic       a_start = 1'b0, b_start = 1'b0;
  logic [6:0] a_dat = '0, b_dat = '0;
  logic       a_tx, b_tx, a_rx_in, b_rx_in;
  logic [6:0] a_rx_dat, b_rx_dat;
  logic       a_vld, b_vld;
  logic       flip_ab = 1'b0, flip_ba = 1'b0;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t  q_a[$];
  exp_t  q_b[$];
  lexp_t lq[$];
  bit    prev_a = 0, prev_b = 0;
  exp_t  me;
  lexp_t le;

  assign b_rx_in = a_tx ^ flip_ab;
  assign a_rx_in = b_tx ^ flip_ba;

  uart a (
    .clk(clk), .rstn(rstn), .tx_start(a_start), .tx_data_in(a_dat),
    .tx_channel_out(a_tx), .rx_channel_in(a_rx_in),
    .rx_data_out(a_rx_dat), .rx_out_vaild(a_vld)
  );

  uart b (
    .clk(clk), .rstn(rstn), .tx_start(b_start), .tx_data_in(b_dat),
    .tx_channel_out(b_tx), .rx_channel_in(b_rx_in),
    .rx_data_out(b_rx_dat), .rx_out_vaild(b_vld)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic bit tx_busy(input bit dir);
    if (dir) return b.tx.state != '0;
    return a.tx.state != '0;
  endfunction

  // Monitor: a receiver finishing a frame (busy -> idle) pops one expectation.
  always @(negedge clk) begin
    if (rstn) begin
      prev_a = 0;
      prev_b = 0;
    end else begin
      if (prev_b && b.rx.state == '0) begin
        if (q_b.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_frame_b got=%0h/%0b expected=none", b_rx_dat, b_vld);
        end else begin
          me = q_b.pop_front();
          chk("b_data", 32'(b_rx_dat), 32'(me.d));
          chk("b_valid", 32'(b_vld), 32'(me.v));
          chk("b_done_cycle", 32'(cyc), me.c);
        end
      end
      prev_b = (b.rx.state != '0);
      if (prev_a && a.rx.state == '0) begin
        if (q_a.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_frame_a got=%0h/%0b expected=none", a_rx_dat, a_vld);
        end else begin
          me = q_a.pop_front();
          chk("a_data", 32'(a_rx_dat), 32'(me.d));
          chk("a_valid", 32'(a_vld), 32'(me.v));
          chk("a_done_cycle", 32'(cyc), me.c);
        end
      end
      prev_a = (a.rx.state != '0);
      if (lq.size() > 0 && lq[0].c == 32'(cyc)) begin
        le = lq.pop_front();
        chk("a_line_bit", 32'(a_tx), 32'(le.b));
      end
    end
  end

  // Sends one frame in direction dir (0: A->B, 1: B->A). Data input toggles after
  // acceptance; hold keeps tx_start high through the frame; flip_k inverts line bit k.
  task automatic send(input bit dir, input logic [6:0] d, input int flip_k,
                      input logic [6:0] ed, input logic ev, input bit hold,
                      input logic [15:0] pat, input bit pat_en);
    int   t0;
    int   budget;
    exp_t e;
    budget = 0;
    while (tx_busy(dir) && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 200) begin
      checks++; errors++;
      $display("FAIL tx_idle_timeout dir=%0d got=busy expected=idle", dir);
      return;
    end
    t0 = cyc;
    if (!dir) begin a_start = 1'b1; a_dat = d; end
    else      begin b_start = 1'b1; b_dat = d; end
    e.d = ed; e.v = ev; e.c = 32'(t0 + 1 + LAT);
    if (!dir) q_b.push_back(e); else q_a.push_back(e);
    if (pat_en)
      for (int k = 0; k <= LAT; k++) lq.push_back('{pat[k], 32'(t0 + 1 + k)});
    for (int k = 1; k <= LAT + 1; k++) begin
      @(negedge clk);
      if (!dir) begin
        a_dat = ~a_dat;
        a_start = hold && (k < LAT);
        flip_ab = (k == flip_k + 1);
      end else begin
        b_dat = ~b_dat;
        b_start = hold && (k < LAT);
        flip_ba = (k == flip_k + 1);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] r;
    repeat (3) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    chk("reset_a_line", 32'(a_tx), 32'd1);
    chk("reset_b_line", 32'(b_tx), 32'd1);
    chk("reset_b_valid", 32'(b_vld), 32'd0);
    chk("reset_b_data", 32'(b_rx_dat), 32'd0);
    chk("reset_a_valid", 32'(a_vld), 32'd0);
    chk("reset_states", 32'({a.tx.state != '0, a.rx.state != '0, b.tx.state != '0, b.rx.state != '0}), 32'd0);

    // Known line patterns.
    send(0, 7'b1011001, -1, 7'b1011001, 1'b1, 0, PAT_59, 1);
    send(0, 7'h2A, -1, 7'h2A, 1'b1, 0, PAT_2A, 1);
    send(0, 7'h7F, -1, 7'h7F, 1'b1, 0, '0, 0);
    send(1, 7'h00, -1, 7'h00, 1'b1, 0, '0, 0);

    // Corrupted frames on the A->B channel.
    send(0, 7'h55, 2, 7'h57, !PAR, 0, '0, 0);
    send(0, 7'h55, 7, 7'h15, !PAR, 0, '0, 0);
    if (PAR) send(0, 7'h55, 8, 7'h55, 1'b0, 0, '0, 0);
    send(0, 7'h55, LAT - 1, 7'h55, 1'b0, 0, '0, 0);
    chk("b_idle_after_framing_err", 32'(b.rx.state != '0), 32'd0);
    send(0, 7'h33, -1, 7'h33, 1'b1, 0, '0, 0);

    // tx_start held high with changing data: only the latched word goes out.
    send(0, 7'h4C, -1, 7'h4C, 1'b1, 1, '0, 0);

    for (int i = 0; i < 50; i++) begin
      r = 7'($urandom);
      send(0, r, -1, r, 1'b1, 0, '0, 0);
    end
    for (int i = 0; i < 50; i++) begin
      r = 7'($urandom);
      send(1, r, -1, r, 1'b1, 0, '0, 0);
    end
    for (int i = 0; i < 10; i++) begin
      logic [6:0] ra, rb;
      ra = 7'($urandom);
      rb = 7'($urandom);
      fork
        send(0, ra, -1, ra, 1'b1, 0, '0, 0);
        send(1, rb, -1, rb, 1'b1, 0, '0, 0);
      join
    end

    // Reset during data bit 3 of a frame.
    while (tx_busy(0)) @(negedge clk);
    a_start = 1'b1;
    a_dat = 7'h00;
    @(negedge clk);
    a_start = 1'b0;
    repeat (4) @(negedge clk);
    chk("line_low_at_bit3", 32'(a_tx), 32'd0);
    #2 rstn = 1'b1;
    #1;
    chk("midframe_reset_line", 32'(a_tx), 32'd1);
    chk("midframe_reset_tx_state", 32'(a.tx.state != '0), 32'd0);
    chk("midframe_reset_rx_state", 32'(b.rx.state != '0), 32'd0);
    @(negedge clk);
    #2 rstn = 1'b0;
    repeat (LAT + 3) @(negedge clk);
    chk("post_reset_b_valid", 32'(b_vld), 32'd0);
    chk("post_reset_b_data", 32'(b_rx_dat), 32'd0);
    chk("post_reset_b_state", 32'(b.rx.state != '0), 32'd0);

    chk("pending_b_frames", 32'(q_b.size()), 32'd0);
    chk("pending_a_frames", 32'(q_a.size()), 32'd0);
    chk("pending_line_bits", 32'(lq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
